// File: rtl/music_player_control.sv
// Audio ROM address sequencer: play/pause, seek with display-timer correction, song select, volume/mute.
// Button actions land on the clock edge that samples the press; pulses (prox_musica, start, mudou_volume) last one cycle.
module music_player_control #(
  parameter int          SAMPLE_RATE = 8000,
  parameter int          HOLD_CYCLES = 64,
  parameter logic [7:0]  END_MARK    = 8'hFF,
  parameter int          VOL_MAX     = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              count,
  input  logic              passa_10s,
  input  logic              volta_10s,
  input  logic              passa_30s,
  input  logic              volta_30s,
  input  logic              prox,
  input  logic              prev,
  input  logic              aumenta,
  input  logic              diminui,
  input  logic              mute,
  input  logic [7:0]        current_value,
  output logic [21:0]       endereco,
  output logic [1:0]        select,
  output logic [23:0]       full_addr,
  output logic signed [8:0] time_adder,
  output logic              prox_musica,
  output logic              start,
  output logic [3:0]        volume1,
  output logic [3:0]        volume0,
  output logic              mudou_volume
);

  localparam int                 HW       = $clog2(HOLD_CYCLES + 1);
  localparam logic [21:0]        ADDR_MAX = 22'h3FFFFF;
  localparam logic signed [24:0] OFF_10   = 25'(10 * SAMPLE_RATE);
  localparam logic signed [24:0] OFF_30   = 25'(30 * SAMPLE_RATE);
  localparam logic signed [24:0] SUM_MAX  = 25'(ADDR_MAX);
  localparam logic [3:0]         VMAX     = 4'(VOL_MAX);

  logic [8:0]        btn_d, btn_q, rise;
  logic [21:0]       endereco_d, endereco_q;
  logic [1:0]        select_d, select_q;
  logic signed [8:0] ta_d, ta_q;
  logic [HW-1:0]     hold_d, hold_q;
  logic              prox_musica_d, prox_musica_q;
  logic              start_d, start_q;
  logic [3:0]        vol_d, vol_q;
  logic              muted_d, muted_q;
  logic              mudou_d, mudou_q;
  logic [3:0]        disp_cur, disp_nxt;

  logic              seek_hit, song_chg;
  logic signed [24:0] seek_off, sum;
  logic signed [8:0] seek_ta;

  logic rise_p30, rise_p10, rise_v30, rise_v10, rise_prox, rise_prev;
  logic rise_aum, rise_dim, rise_mute;

  always_comb begin
    btn_d = {mute, diminui, aumenta, prev, prox, volta_10s, volta_30s, passa_10s, passa_30s};
  end

  assign rise      = btn_d & ~btn_q;
  assign rise_p30  = rise[0];
  assign rise_p10  = rise[1];
  assign rise_v30  = rise[2];
  assign rise_v10  = rise[3];
  assign rise_prox = rise[4];
  assign rise_prev = rise[5];
  assign rise_aum  = rise[6];
  assign rise_dim  = rise[7];
  assign rise_mute = rise[8];

  assign disp_cur = muted_q ? 4'd0 : vol_q;

  always_comb begin
    endereco_d    = endereco_q;
    select_d      = select_q;
    ta_d          = ta_q;
    hold_d        = hold_q;
    prox_musica_d = 1'b0;
    start_d       = 1'b0;
    song_chg      = 1'b0;
    seek_hit      = 1'b1;
    seek_off      = '0;
    seek_ta       = 9'sd1;

    if (rise_p30) begin
      seek_off = OFF_30;
      seek_ta  = 9'sd31;
    end else if (rise_p10) begin
      seek_off = OFF_10;
      seek_ta  = 9'sd11;
    end else if (rise_v30) begin
      seek_off = -OFF_30;
      seek_ta  = -9'sd29;
    end else if (rise_v10) begin
      seek_off = -OFF_10;
      seek_ta  = -9'sd9;
    end else begin
      seek_hit = 1'b0;
    end
    sum = $signed({3'b000, endereco_q}) + seek_off;

    // Hold window decays unless something below reloads or cancels it.
    if (hold_q != '0) hold_d = hold_q - 1'b1;
    else              ta_d   = 9'sd1;

    // An end-of-song pulse always advances, even against a concurrent prev press.
    if (prox_musica_q || (rise_prox && !rise_prev)) begin
      select_d = select_q + 2'd1;
      song_chg = 1'b1;
    end else if (rise_prev && !rise_prox) begin
      select_d = select_q - 2'd1;
      song_chg = 1'b1;
    end

    if (song_chg) begin
      start_d    = 1'b1;
      endereco_d = '0;
      ta_d       = 9'sd1;
      hold_d     = '0;
    end else if (seek_hit) begin
      if (sum > SUM_MAX) begin
        prox_musica_d = 1'b1;
      end else begin
        endereco_d = (sum < 25'sd0) ? 22'd0 : sum[21:0];
        ta_d       = seek_ta;
        hold_d     = HW'(HOLD_CYCLES - 1);
      end
    end else if (count) begin
      if (endereco_q == ADDR_MAX || current_value == END_MARK) prox_musica_d = 1'b1;
      else                                                    endereco_d    = endereco_q + 22'd1;
    end
  end

  always_comb begin
    vol_d   = vol_q;
    muted_d = muted_q ^ rise_mute;
    if (!muted_q && (rise_aum ^ rise_dim)) begin
      if (rise_aum && vol_q < VMAX)       vol_d = vol_q + 4'd1;
      else if (rise_dim && vol_q != 4'd0) vol_d = vol_q - 4'd1;
    end
    disp_nxt = muted_d ? 4'd0 : vol_d;
    mudou_d  = (disp_nxt != disp_cur);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      btn_q         <= '0;
      endereco_q    <= '0;
      select_q      <= '0;
      ta_q          <= 9'sd1;
      hold_q        <= '0;
      prox_musica_q <= 1'b0;
      start_q       <= 1'b0;
      vol_q         <= 4'd5;
      muted_q       <= 1'b0;
      mudou_q       <= 1'b0;
    end else begin
      btn_q         <= btn_d;
      endereco_q    <= endereco_d;
      select_q      <= select_d;
      ta_q          <= ta_d;
      hold_q        <= hold_d;
      prox_musica_q <= prox_musica_d;
      start_q       <= start_d;
      vol_q         <= vol_d;
      muted_q       <= muted_d;
      mudou_q       <= mudou_d;
    end
  end

  assign endereco     = endereco_q;
  assign select       = select_q;
  assign full_addr    = {select_q, endereco_q};
  assign time_adder   = ta_q;
  assign prox_musica  = prox_musica_q;
  assign start        = start_q;
  assign mudou_volume = mudou_q;
  assign volume1      = (disp_cur >= 4'd10) ? 4'd1 : 4'd0;
  assign volume0      = (disp_cur >= 4'd10) ? disp_cur - 4'd10 : disp_cur;

endmodule

// File: tb/tb_music_player_control.sv
// Bench for music_player_control: directed scenarios plus a randomized run against a cycle-level behavioural model.
module tb_music_player_control;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              count = 1'b0;
  logic              passa_10s = 1'b0, volta_10s = 1'b0, passa_30s = 1'b0, volta_30s = 1'b0;
  logic              prox = 1'b0, prev = 1'b0;
  logic              aumenta = 1'b0, diminui = 1'b0, mute = 1'b0;
  logic [7:0]        current_value = 8'h00;
  logic [21:0]       endereco;
  logic [1:0]        select;
  logic [23:0]       full_addr;
  logic signed [8:0] time_adder;
  logic              prox_musica, start, mudou_volume;
  logic [3:0]        volume1, volume0;

  int n_chk = 0;
  int n_fail = 0;

  // Reference state in plain integers.
  int m_addr, m_sel, m_ta, m_hold, m_vol;
  bit m_pm, m_start, m_muted, m_mud;
  bit p_btn [9];

  localparam int SR = 8000;
  localparam int AMAX = 4194303;

  music_player_control dut (
    .clk(clk), .reset(reset), .count(count),
    .passa_10s(passa_10s), .volta_10s(volta_10s), .passa_30s(passa_30s), .volta_30s(volta_30s),
    .prox(prox), .prev(prev), .aumenta(aumenta), .diminui(diminui), .mute(mute),
    .current_value(current_value), .endereco(endereco), .select(select), .full_addr(full_addr),
    .time_adder(time_adder), .prox_musica(prox_musica), .start(start),
    .volume1(volume1), .volume0(volume0), .mudou_volume(mudou_volume)
  );

  always #5 clk = ~clk;

  task automatic model_step();
    bit cur [9];
    bit e [9];
    int dsel, off, tv, na, disp_old, disp_new;
    bit seek, loaded;
    cur = '{passa_30s, passa_10s, volta_30s, volta_10s, prox, prev, aumenta, diminui, mute};
    for (int i = 0; i < 9; i++) e[i] = cur[i] && !p_btn[i];
    if (!reset) begin
      m_addr = 0; m_sel = 0; m_ta = 1; m_hold = 0; m_pm = 0; m_start = 0;
      m_vol = 5; m_muted = 0; m_mud = 0;
      for (int i = 0; i < 9; i++) p_btn[i] = 0;
      return;
    end
    disp_old = m_muted ? 0 : m_vol;
    dsel = 0;
    if (m_pm) dsel = 1;
    else if (e[4] && !e[5]) dsel = 1;
    else if (e[5] && !e[4]) dsel = -1;
    seek = 1; off = 0; tv = 1;
    if (e[0])      begin off = 30 * SR;  tv = 31;  end
    else if (e[1]) begin off = 10 * SR;  tv = 11;  end
    else if (e[2]) begin off = -30 * SR; tv = -29; end
    else if (e[3]) begin off = -10 * SR; tv = -9;  end
    else seek = 0;
    loaded = 0;
    m_start = 0;
    m_pm = 0;
    if (dsel != 0) begin
      m_sel = (m_sel + dsel + 4) % 4;
      m_start = 1; m_addr = 0; m_ta = 1; m_hold = 0; loaded = 1;
    end else if (seek) begin
      na = m_addr + off;
      if (na > AMAX) m_pm = 1;
      else begin
        m_addr = (na < 0) ? 0 : na;
        m_ta = tv; m_hold = 64; loaded = 1;
      end
    end else if (count) begin
      if (m_addr == AMAX || current_value == 8'hFF) m_pm = 1;
      else m_addr++;
    end
    if (!loaded) begin
      if (m_hold > 0) m_hold--;
      if (m_hold == 0) m_ta = 1;
    end
    if (!m_muted && (e[6] != e[7])) begin
      if (e[6]) m_vol = (m_vol < 10) ? m_vol + 1 : 10;
      else      m_vol = (m_vol > 0) ? m_vol - 1 : 0;
    end
    if (e[8]) m_muted = !m_muted;
    disp_new = m_muted ? 0 : m_vol;
    m_mud = (disp_new != disp_old);
    for (int i = 0; i < 9; i++) p_btn[i] = cur[i];
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic clear_inputs();
    count = 0; passa_10s = 0; volta_10s = 0; passa_30s = 0; volta_30s = 0;
    prox = 0; prev = 0; aumenta = 0; diminui = 0; mute = 0; current_value = 8'h00;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 0;
    tick(); tick();
    reset = 1;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 0;
    tick(); tick();
    n_chk++; if (endereco !== 22'd0) begin n_fail++; $display("FAIL reset_endereco got %0d want 0", endereco); end
    n_chk++; if (select !== 2'd0) begin n_fail++; $display("FAIL reset_select got %0d want 0", select); end
    n_chk++; if (time_adder !== 9'sd1) begin n_fail++; $display("FAIL reset_time_adder got %0d want 1", time_adder); end
    n_chk++; if ({prox_musica, start, mudou_volume} !== 3'b000) begin n_fail++; $display("FAIL reset_pulses got %b want 000", {prox_musica, start, mudou_volume}); end
    n_chk++; if ({volume1, volume0} !== 8'h05) begin n_fail++; $display("FAIL reset_volume got %h want 05", {volume1, volume0}); end
    reset = 1;
  endtask

  task automatic test_count();
    do_reset();
    count = 1;
    repeat (100) tick();
    n_chk++; if (endereco !== 22'd100) begin n_fail++; $display("FAIL count_100 got %0d want 100", endereco); end
    n_chk++; if (select !== 2'd0 || time_adder !== 9'sd1) begin n_fail++; $display("FAIL count_sel_ta got %0d/%0d want 0/1", select, time_adder); end
    count = 0;
    repeat (5) tick();
    n_chk++; if (endereco !== 22'd100) begin n_fail++; $display("FAIL pause_hold got %0d want 100", endereco); end
  endtask

  task automatic test_seek_back();
    int bad;
    do_reset();
    count = 1;
    repeat (50) tick();
    count = 0;
    volta_10s = 1; tick(); volta_10s = 0;
    n_chk++; if (endereco !== 22'd0) begin n_fail++; $display("FAIL clamp_zero got %0d want 0", endereco); end
    n_chk++; if (time_adder !== -9'sd9) begin n_fail++; $display("FAIL back_ta got %0d want -9", time_adder); end
    bad = 0;
    repeat (63) begin tick(); if (time_adder !== -9'sd9) bad++; end
    n_chk++; if (bad != 0) begin n_fail++; $display("FAIL back_window got %0d wrong cycles want 0", bad); end
    tick();
    n_chk++; if (time_adder !== 9'sd1) begin n_fail++; $display("FAIL back_window_end got %0d want 1", time_adder); end
  endtask

  task automatic test_seek_fwd();
    do_reset();
    count = 1;
    repeat (10) tick();
    passa_30s = 1; tick(); passa_30s = 0;
    n_chk++; if (endereco !== 22'd240010) begin n_fail++; $display("FAIL fwd30 got %0d want 240010", endereco); end
    n_chk++; if (time_adder !== 9'sd31) begin n_fail++; $display("FAIL fwd30_ta got %0d want 31", time_adder); end
    tick();
    n_chk++; if (endereco !== 22'd240011) begin n_fail++; $display("FAIL fwd_then_count got %0d want 240011", endereco); end
    count = 0;
  endtask

  task automatic test_priority();
    int bad;
    do_reset();
    passa_30s = 1; tick(); passa_30s = 0; tick();
    passa_10s = 1; volta_30s = 1; volta_10s = 1; tick();
    passa_10s = 0; volta_30s = 0; volta_10s = 0;
    n_chk++; if (endereco !== 22'd320000 || time_adder !== 9'sd11) begin n_fail++; $display("FAIL prio_p10 got %0d/%0d want 320000/11", endereco, time_adder); end
    tick();
    volta_30s = 1; volta_10s = 1; tick(); volta_30s = 0; volta_10s = 0;
    n_chk++; if (endereco !== 22'd80000 || time_adder !== -9'sd29) begin n_fail++; $display("FAIL prio_v30 got %0d/%0d want 80000/-29", endereco, time_adder); end
    repeat (30) tick();
    passa_10s = 1; tick(); passa_10s = 0;
    bad = 0;
    repeat (63) begin tick(); if (time_adder !== 9'sd11) bad++; end
    n_chk++; if (bad != 0) begin n_fail++; $display("FAIL restart_window got %0d wrong cycles want 0", bad); end
    tick();
    n_chk++; if (time_adder !== 9'sd1) begin n_fail++; $display("FAIL restart_window_end got %0d want 1", time_adder); end
    passa_10s = 1; tick(); passa_10s = 0;
    reset = 0; tick(); reset = 1;
    n_chk++; if (time_adder !== 9'sd1 || endereco !== 22'd0) begin n_fail++; $display("FAIL reset_mid got %0d/%0d want 1/0", time_adder, endereco); end
  endtask

  task automatic test_song();
    do_reset();
    prev = 1; tick();
    n_chk++; if (select !== 2'd3 || start !== 1'b1) begin n_fail++; $display("FAIL prev_wrap got sel %0d start %b want 3 1", select, start); end
    tick();
    n_chk++; if (select !== 2'd3 || start !== 1'b0) begin n_fail++; $display("FAIL prev_held got sel %0d start %b want 3 0", select, start); end
    prev = 0; tick();
    count = 1; repeat (7) tick(); count = 0;
    prox = 1; tick(); prox = 0;
    n_chk++; if (select !== 2'd0 || start !== 1'b1 || endereco !== 22'd0) begin n_fail++; $display("FAIL prox_wrap got sel %0d start %b addr %0d want 0 1 0", select, start, endereco); end
    tick();
    prox = 1; prev = 1; tick(); prox = 0; prev = 0;
    n_chk++; if (select !== 2'd0 || start !== 1'b0) begin n_fail++; $display("FAIL both_ignored got sel %0d start %b want 0 0", select, start); end
    passa_10s = 1; tick(); passa_10s = 0;
    prox = 1; tick(); prox = 0;
    n_chk++; if (select !== 2'd1 || time_adder !== 9'sd1 || endereco !== 22'd0) begin n_fail++; $display("FAIL song_cancels_hold got sel %0d ta %0d addr %0d want 1 1 0", select, time_adder, endereco); end
    tick();
    count = 1; current_value = 8'hFF; tick();
    n_chk++; if (prox_musica !== 1'b1 || select !== 2'd1) begin n_fail++; $display("FAIL end_mark_pulse got pm %b sel %0d want 1 1", prox_musica, select); end
    tick();
    n_chk++; if (prox_musica !== 1'b0 || select !== 2'd2 || endereco !== 22'd0 || start !== 1'b1) begin n_fail++; $display("FAIL end_mark_next got pm %b sel %0d addr %0d start %b want 0 2 0 1", prox_musica, select, endereco, start); end
    count = 0; current_value = 8'h00; tick();
    for (int i = 0; i < 17; i++) begin passa_30s = 1; tick(); passa_30s = 0; tick(); end
    n_chk++; if (endereco !== 22'd4080000) begin n_fail++; $display("FAIL seek_stack got %0d want 4080000", endereco); end
    passa_30s = 1; tick(); passa_30s = 0;
    n_chk++; if (prox_musica !== 1'b1 || endereco !== 22'd4080000) begin n_fail++; $display("FAIL overflow_pulse got pm %b addr %0d want 1 4080000", prox_musica, endereco); end
    tick();
    n_chk++; if (select !== 2'd3 || endereco !== 22'd0 || prox_musica !== 1'b0) begin n_fail++; $display("FAIL overflow_next got sel %0d addr %0d pm %b want 3 0 0", select, endereco, prox_musica); end
  endtask

  task automatic test_volume();
    int pulses;
    int exp_v;
    do_reset();
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      aumenta = 1;
      for (int c = 0; c < 25; c++) begin tick(); if (mudou_volume === 1'b1) pulses++; end
      aumenta = 0; tick(); if (mudou_volume === 1'b1) pulses++;
      exp_v = (6 + i > 10) ? 10 : 6 + i;
      n_chk++; if (volume1 * 10 + volume0 !== exp_v) begin n_fail++; $display("FAIL vol_up_%0d got %0d%0d want %0d", i, volume1, volume0, exp_v); end
    end
    n_chk++; if (pulses != 5) begin n_fail++; $display("FAIL vol_pulses got %0d want 5", pulses); end
    mute = 1; tick(); mute = 0;
    n_chk++; if ({volume1, volume0} !== 8'h00 || mudou_volume !== 1'b1) begin n_fail++; $display("FAIL mute_on got %h pulse %b want 00 1", {volume1, volume0}, mudou_volume); end
    tick();
    diminui = 1; tick(); diminui = 0;
    n_chk++; if ({volume1, volume0} !== 8'h00 || mudou_volume !== 1'b0) begin n_fail++; $display("FAIL muted_ignore got %h pulse %b want 00 0", {volume1, volume0}, mudou_volume); end
    tick();
    mute = 1; tick(); mute = 0;
    n_chk++; if ({volume1, volume0} !== 8'h10 || mudou_volume !== 1'b1) begin n_fail++; $display("FAIL mute_off got %h pulse %b want 10 1", {volume1, volume0}, mudou_volume); end
    tick();
    aumenta = 1; diminui = 1; tick(); aumenta = 0; diminui = 0;
    n_chk++; if ({volume1, volume0} !== 8'h10 || mudou_volume !== 1'b0) begin n_fail++; $display("FAIL vol_both got %h pulse %b want 10 0", {volume1, volume0}, mudou_volume); end
    for (int i = 0; i < 11; i++) begin diminui = 1; tick(); diminui = 0; tick(); end
    n_chk++; if ({volume1, volume0} !== 8'h00 || mudou_volume !== 1'b0) begin n_fail++; $display("FAIL vol_floor got %h pulse %b want 00 0", {volume1, volume0}, mudou_volume); end
  endtask

  task automatic test_random();
    int bad_addr, bad_sel, bad_ta, bad_pulse, bad_vol;
    bad_addr = 0; bad_sel = 0; bad_ta = 0; bad_pulse = 0; bad_vol = 0;
    for (int c = 0; c < 4000; c++) begin
      reset         = ($urandom_range(0, 599) != 0);
      count         = ($urandom_range(0, 7) != 0);
      passa_10s     = ($urandom_range(0, 9) == 0);
      volta_10s     = ($urandom_range(0, 9) == 0);
      passa_30s     = ($urandom_range(0, 7) == 0);
      volta_30s     = ($urandom_range(0, 11) == 0);
      prox          = ($urandom_range(0, 29) == 0);
      prev          = ($urandom_range(0, 29) == 0);
      aumenta       = ($urandom_range(0, 5) == 0);
      diminui       = ($urandom_range(0, 5) == 0);
      mute          = ($urandom_range(0, 15) == 0);
      current_value = ($urandom_range(0, 79) == 0) ? 8'hFF : 8'($urandom_range(0, 254));
      tick();
      n_chk++; if (endereco !== 22'(m_addr) || full_addr !== {2'(m_sel), 22'(m_addr)}) begin n_fail++; bad_addr++;
        if (bad_addr < 4) $display("FAIL rnd_addr cycle %0d got %0d/%h want %0d", c, endereco, full_addr, m_addr); end
      n_chk++; if (select !== 2'(m_sel)) begin n_fail++; bad_sel++;
        if (bad_sel < 4) $display("FAIL rnd_select cycle %0d got %0d want %0d", c, select, m_sel); end
      n_chk++; if (time_adder !== 9'(m_ta)) begin n_fail++; bad_ta++;
        if (bad_ta < 4) $display("FAIL rnd_time_adder cycle %0d got %0d want %0d", c, time_adder, m_ta); end
      n_chk++; if ({prox_musica, start, mudou_volume} !== {m_pm, m_start, m_mud}) begin n_fail++; bad_pulse++;
        if (bad_pulse < 4) $display("FAIL rnd_pulses cycle %0d got %b want %b", c, {prox_musica, start, mudou_volume}, {m_pm, m_start, m_mud}); end
      n_chk++; if (volume1 !== 4'((m_muted ? 0 : m_vol) / 10) || volume0 !== 4'((m_muted ? 0 : m_vol) % 10)) begin n_fail++; bad_vol++;
        if (bad_vol < 4) $display("FAIL rnd_volume cycle %0d got %0d%0d want %0d", c, volume1, volume0, m_muted ? 0 : m_vol); end
    end
    reset = 1;
  endtask

  initial begin
    test_reset();
    test_count();
    test_seek_back();
    test_seek_fwd();
    test_priority();
    test_song();
    test_volume();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
